bit_serial_sub: RTL and testbench
=================================

Name: bit_serial_sub

Overview:
- Sequential bit-serial subtractor; the inverse-direction companion of the team's bit-serial adder.
- Takes two parallel operands, computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
- Returns a parallel difference plus borrow and zero flags, with a start/busy/done handshake for the sequencing controller in the datapath lab.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values: 2 or more).
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- res  input  1  asynchronous, active-low reset; clears all state immediately when low.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while the subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  final borrow-out; 1 means a < b (unsigned).
- zero  output  1  1 when diff == 0.

Behaviour:
- Reset (res low, asynchronous): state = IDLE, all shift registers cleared, borrow flop cleared, counter = 0.
- Output values under reset: busy = 0, done = 0, diff = 0, borrow = 0, zero = 0.
- Reset mid-operation aborts the operation with no done pulse. Normal operation resumes on the first clock edge after res returns high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on a rising edge with start = 1:
  - load sa <= a and sb <= b;
  - clear the borrow flop and set count <= 0;
  - go to SHIFT.
  - diff, borrow and zero keep their previous values.
- SHIFT: each edge performs one bit step.
  - Bit slice: d = sa[0] ^ sb[0] ^ bin; bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin).
  - Updates: sa and sb shift right (zero fill); the difference register shifts right with d inserted at the MSB; bin <= bout; count <= count + 1.
  - When count reaches WIDTH-1 on that edge, go to DONE.
- Register updates on the DONE transition edge:
  - diff <= final shifted value;
  - borrow <= final bout;
  - zero <= (final diff == 0).
- DONE: done = 1 for exactly one cycle, then unconditionally IDLE.
- busy = 1 only in SHIFT.
- Latency: start accepted at edge k; done is high during the cycle after edge k+WIDTH. For WIDTH = 8, done follows 9 edges after start.
- Throughput: one operation per WIDTH+2 cycles.
- start during SHIFT or DONE is ignored. No queuing; the operands on a and b are not re-sampled.
- a and b may change freely after the accepted start edge without affecting the result.
- diff, borrow and zero hold their values until the next operation's DONE edge or reset.
- Wrap-around: results are modulo 2^WIDTH; borrow is the only overflow indication. No signed flag.
- No X propagation from an unused start; outputs remain defined at all times after reset.

Decomposition:
- Shared package bsub_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - localparam encodings for those states;
  - the default WIDTH constant, shared with the bit-serial adder so both blocks agree on operand size.
- One natural sub-module: full_sub_1b, combinational.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Instantiated once, sitting between the operand LSBs and the borrow flop.
- Counter, shift registers and FSM stay in the top module.

Test Plan:
- Reset, then a = 8'h2D, b = 8'hBF, start pulse -> busy for 8 cycles; done pulses 9 edges after start; diff = 8'h6E, borrow = 1, zero = 0.
- a = 8'hBF, b = 8'h2D -> diff = 8'h92, borrow = 0, zero = 0.
- a = 8'h55, b = 8'h55 -> diff = 8'h00, borrow = 0, zero = 1. Then a = 8'h00, b = 8'h01 -> diff = 8'hFF, borrow = 1, zero = 0 (wrap-around).
- Start a = 8'h10, b = 8'h01. During SHIFT assert start with a = 8'hFF, b = 8'hFF and change the a/b inputs -> exactly one done; diff = 8'h0F, borrow = 0; second start ignored.
- Pull res low at the 4th SHIFT cycle -> busy, done, diff, borrow and zero go to 0 immediately with no clock edge needed; no done pulse. After release, a new start with a = 8'h03, b = 8'h02 gives diff = 8'h01.
- Back-to-back: re-assert start on the cycle after done -> second operation accepted; result valid after another WIDTH+1 edges; done is never high two cycles in a row.

Source files
------------

// File: rtl/bsub_pkg.sv
// Shared definitions for the bit-serial subtractor and its adder sibling.
// Both blocks take their default operand width from here so they always agree.
package bsub_pkg;

  localparam int BSUB_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/bit_serial_sub_full_sub_1b.sv
// One-bit full subtractor: x - y - bin gives difference d and borrow-out bout.
module full_sub_1b (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A start/busy/done handshake is used, and the diff/borrow/zero results stay
// unchanged until the next completed operation.
module bit_serial_sub
  import bsub_pkg::*;
#(
  parameter  int WIDTH = BSUB_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_dacc;
  logic             r_bin;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_dacc_next;

  full_sub_1b u_cell (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // The new difference bit enters at the MSB, so after WIDTH steps the LSB has reached bit 0.
  assign w_dacc_next = {w_d, r_dacc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_dacc   <= '0;
      r_bin    <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_dacc  <= '0;
            r_bin   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_dacc  <= w_dacc_next;
          r_bin   <= w_bout;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_diff   <= w_dacc_next;
            r_borrow <= w_bout;
            r_zero   <= (w_dacc_next == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign zero   = r_zero;

endmodule

// File: tb/tb_bit_serial_sub.sv
// Directed self-checking bench for bit_serial_sub with hand-computed results.
module tb_bit_serial_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  int testCount = 0;
  int failCount = 0;
  int edges;
  int busyCyc;
  int doneSeen;

  bit_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start pulse and returns at the negedge just after the start edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int nEdges, output int nBusy);
    nEdges = 0;
    nBusy = 0;
    while (done !== 1'b1 && nEdges < 40) begin
      if (busy === 1'b1) nBusy++;
      @(negedge clk);
      nEdges++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] expDiff,
                             input logic expBorrow, input logic expZero);
    waitDone(edges, busyCyc);
    checkOutput({tag, "_latency"}, edges, WIDTH);
    checkOutput({tag, "_busyCycles"}, busyCyc, WIDTH);
    checkOutput({tag, "_busyAtDone"}, busy, 1'b0);
    checkOutput({tag, "_diff"}, diff, expDiff);
    checkOutput({tag, "_borrow"}, borrow, expBorrow);
    checkOutput({tag, "_zero"}, zero, expZero);
    @(negedge clk);
    checkOutput({tag, "_donePulseOnly"}, done, 1'b0);
  endtask

  initial begin
    #2;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_diff", diff, 8'h00);
    checkOutput("rst_borrow", borrow, 1'b0);
    checkOutput("rst_zero", zero, 1'b0);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);

    applyStimulus(8'h2D, 8'hBF);
    checkOutput("op1_busyAfterStart", busy, 1'b1);
    checkResult("op1", 8'h6E, 1'b1, 1'b0);

    applyStimulus(8'hBF, 8'h2D);
    @(negedge clk);
    @(negedge clk);
    checkOutput("op2_diffHeldMidShift", diff, 8'h6E);
    waitDone(edges, busyCyc);
    checkOutput("op2_latencyRemaining", edges, WIDTH - 2);
    checkOutput("op2_diff", diff, 8'h92);
    checkOutput("op2_borrow", borrow, 1'b0);
    checkOutput("op2_zero", zero, 1'b0);
    @(negedge clk);

    applyStimulus(8'h55, 8'h55);
    checkResult("equal", 8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h01);
    checkResult("wrap", 8'hFF, 1'b1, 1'b0);

    applyStimulus(8'h10, 8'h01);
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    waitDone(edges, busyCyc);
    checkOutput("ignore_latency", edges, WIDTH - 2);
    checkOutput("ignore_diff", diff, 8'h0F);
    checkOutput("ignore_borrow", borrow, 1'b0);
    checkOutput("ignore_zero", zero, 1'b0);
    doneSeen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checkOutput("ignore_noSecondOp", doneSeen, 0);

    applyStimulus(8'h80, 8'h01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    res = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_diff", diff, 8'h00);
    checkOutput("abort_borrow", borrow, 1'b0);
    checkOutput("abort_zero", zero, 1'b0);
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    res = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort_noDone", doneSeen, 0);
    applyStimulus(8'h03, 8'h02);
    checkResult("afterAbort", 8'h01, 1'b0, 1'b0);

    applyStimulus(8'h2D, 8'hBF);
    waitDone(edges, busyCyc);
    checkOutput("b2b_first_diff", diff, 8'h6E);
    @(negedge clk);
    checkOutput("b2b_doneDrop", done, 1'b0);
    a = 8'hBF;
    b = 8'h2D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accepted", busy, 1'b1);
    checkResult("b2b_second", 8'h92, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
